mem_arbiter_ctrl: RTL and testbench

- Owns the single byte-wide RAM/IO port.
- Arbitrates between two requesters:
  - the Instruction Fetcher: fixed-size instruction read;
  - the Load Store Buffer: 1/2/4-byte load or store.
- Sequences each transaction as a pipelined byte stream and returns assembled little-endian data with a one-cycle done pulse.
- Aborts speculative reads on rollback.

---
 rtl/mem_arbiter_ctrl_if.sv | 36 +++
 rtl/mem_arbiter_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_ctrl_if.sv
// Request/response and byte-wide RAM port bundle between the arbiter (slave) and its environment (master).
// Purely wiring: no latency of its own; requesters hold *_en until the matching done pulse.
interface mem_arbiter_ctrl_if #(
  parameter int IF_BYTES = 4
);
  logic                    rdy;
  logic                    rollback;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [31:0]             mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;
  logic                    if_en;
  logic [31:0]             if_pc;
  logic                    if_done;
  logic [8*IF_BYTES-1:0]   if_data;
  logic                    lsb_en;
  logic                    lsb_wr;
  logic [31:0]             lsb_addr;
  logic [2:0]              lsb_len;
  logic [31:0]             lsb_w_data;
  logic                    lsb_done;
  logic [31:0]             lsb_r_data;

  modport master (
    output rdy, rollback, mem_din, io_buffer_full,
    output if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    input  mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );

  modport slave (
    input  rdy, rollback, mem_din, io_buffer_full,
    input  if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    output mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates fetch and load/store onto one byte RAM port; reads complete N+1 edges and writes N edges after grant.
// Requesters hold en until a one-cycle done; rdy low freezes everything; stores to a full IO buffer wait in IDLE.
module mem_arbiter_ctrl #(
  parameter int         IF_BYTES   = 4,
  parameter logic [1:0] IO_MASK_HI = 2'b11
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_arbiter_ctrl_if.slave    bus
);

  localparam int         DW   = 8 * IF_BYTES;
  localparam int         IW   = $clog2(IF_BYTES);
  localparam logic [6:0] IF_N = 7'(IF_BYTES);

  typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;
  typedef enum logic {GRANT_IF, GRANT_LSB} grant_t;

  state_t          state_q, state_d;
  grant_t          last_grant_q, last_grant_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [6:0]      n_q, n_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     mem_a_q, mem_a_d;
  logic [7:0]      mem_dout_q, mem_dout_d;
  logic            mem_wr_q, mem_wr_d;
  logic            if_done_q, if_done_d;
  logic            lsb_done_q, lsb_done_d;
  logic [DW-1:0]   if_data_q, if_data_d;
  logic [31:0]     lsb_r_data_q, lsb_r_data_d;

  logic            io_blocked;
  logic            if_elig;
  logic            lsb_elig;
  logic            grant_if;
  logic            grant_lsb;
  logic [6:0]      bidx;
  logic [31:0]     next_a;

  always_comb begin
    io_blocked = bus.lsb_wr && (bus.lsb_addr[17:16] == IO_MASK_HI) && bus.io_buffer_full;
    if_elig    = bus.if_en && !bus.rollback;
    // A rollback only kills speculative reads; a store request may still be granted.
    lsb_elig   = bus.lsb_en && !io_blocked && (bus.lsb_wr || !bus.rollback);
    grant_lsb  = lsb_elig && (!if_elig || (last_grant_q == GRANT_IF));
    grant_if   = if_elig && !grant_lsb;
    bidx       = cnt_q - 7'd2;
    next_a     = base_q + {25'd0, cnt_q};

    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    if_done_d    = if_done_q;
    lsb_done_d   = lsb_done_q;
    if_data_d    = if_data_q;
    lsb_r_data_d = lsb_r_data_q;

    if (bus.rdy) begin
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          // The done cycle is never a grant cycle, giving a one-cycle gap between transactions.
          if (!if_done_q && !lsb_done_q) begin
            if (grant_if) begin
              state_d      = IF_READ;
              last_grant_d = GRANT_IF;
              base_d       = bus.if_pc;
              n_d          = IF_N;
              cnt_d        = 7'd1;
              mem_a_d      = bus.if_pc;
              mem_wr_d     = 1'b0;
              if_data_d    = '0;
            end else if (grant_lsb) begin
              last_grant_d = GRANT_LSB;
              base_d       = bus.lsb_addr;
              n_d          = {4'd0, bus.lsb_len};
              cnt_d        = 7'd1;
              mem_a_d      = bus.lsb_addr;
              wdata_d      = bus.lsb_w_data;
              if (bus.lsb_wr) begin
                state_d    = LS_WRITE;
                mem_wr_d   = 1'b1;
                mem_dout_d = bus.lsb_w_data[7:0];
              end else begin
                state_d      = LS_READ;
                mem_wr_d     = 1'b0;
                lsb_r_data_d = '0;
              end
            end
          end
        end
        IF_READ, LS_READ: begin
          if (bus.rollback) begin
            state_d = IDLE;
            mem_a_d = '0;
            cnt_d   = '0;
            if (state_q == IF_READ) if_data_d = '0;
            else                    lsb_r_data_d = '0;
          end else begin
            // RAM returns the byte for address base+k two edges after it was presented.
            if ((cnt_q >= 7'd2) && (bidx < n_q)) begin
              if (state_q == IF_READ) if_data_d[{bidx[IW-1:0], 3'b000} +: 8] = bus.mem_din;
              else                    lsb_r_data_d[{bidx[1:0], 3'b000} +: 8] = bus.mem_din;
            end
            if (cnt_q >= n_q + 7'd1) begin
              state_d = IDLE;
              mem_a_d = '0;
              cnt_d   = '0;
              if (state_q == IF_READ) if_done_d = 1'b1;
              else                    lsb_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 7'd1;
              if (cnt_q < n_q) mem_a_d = next_a;
            end
          end
        end
        LS_WRITE: begin
          if (cnt_q >= n_q) begin
            state_d    = IDLE;
            mem_wr_d   = 1'b0;
            mem_a_d    = '0;
            cnt_d      = '0;
            lsb_done_d = 1'b1;
          end else begin
            mem_a_d    = next_a;
            mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_d      = cnt_q + 7'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_IF;
      cnt_q        <= '0;
      n_q          <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_data_q    <= '0;
      lsb_r_data_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
      if_data_q    <= if_data_d;
      lsb_r_data_q <= lsb_r_data_d;
    end
  end

  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.if_done    = if_done_q;
  assign bus.lsb_done   = lsb_done_q;
  assign bus.if_data    = if_data_q;
  assign bus.lsb_r_data = lsb_r_data_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: stimulus queues expected writes and done responses,
// a negedge monitor pops and compares them against the DUT and a byte RAM model.
module tb_mem_arbiter_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic ram_init;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_ctrl_if #(.IF_BYTES(4)) bus ();

  mem_arbiter_ctrl #(.IF_BYTES(4), .IO_MASK_HI(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_if;
    logic        chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wexp_t;

  exp_t  dq[$];
  wexp_t wq[$];

  // Byte RAM folded onto 64K entries; registered read, stalls on rdy like the real RAM.
  logic [7:0] ram [0:65535];

  function automatic logic [15:0] ridx(input logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'd0};
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
      ram[ridx(18'h01000)] <= 8'h13;
      ram[ridx(18'h01001)] <= 8'h05;
      ram[ridx(18'h01002)] <= 8'h10;
      ram[ridx(18'h01003)] <= 8'h00;
      ram[ridx(18'h3FFFF)] <= 8'h77;
      ram[ridx(18'h00000)] <= 8'h66;
      bus.mem_din <= 8'h00;
    end else if (bus.rdy) begin
      if (bus.mem_wr) ram[ridx(bus.mem_a[17:0])] <= bus.mem_dout;
      bus.mem_din <= ram[ridx(bus.mem_a[17:0])];
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_done(input logic is_if, input logic chk_data, input logic [31:0] data, input int c);
    exp_t e;
    e.is_if = is_if; e.chk_data = chk_data; e.data = data; e.cyc = c;
    dq.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
    wexp_t w;
    w.a = a; w.d = d;
    wq.push_back(w);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_mem_a"},      bus.mem_a,      0);
    chk({name, "_mem_dout"},   bus.mem_dout,   0);
    chk({name, "_mem_wr"},     bus.mem_wr,     0);
    chk({name, "_if_done"},    bus.if_done,    0);
    chk({name, "_lsb_done"},   bus.lsb_done,   0);
    chk({name, "_if_data"},    bus.if_data,    0);
    chk({name, "_lsb_r_data"}, bus.lsb_r_data, 0);
  endtask

  task automatic if_drive(input logic [31:0] pc);
    bus.if_pc = pc;
    bus.if_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.if_done) begin
        bus.if_en = 1'b0;
        return;
      end
    end
    bus.if_en = 1'b0;
    checks++; errors++;
    $display("FAIL if_timeout pc=%h got if_done=0 required if_done=1", pc);
  endtask

  task automatic lsb_drive(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                           input logic [31:0] data);
    bus.lsb_wr     = wr;
    bus.lsb_addr   = addr;
    bus.lsb_len    = len;
    bus.lsb_w_data = data;
    bus.lsb_en     = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.lsb_done) begin
        bus.lsb_en = 1'b0;
        return;
      end
    end
    bus.lsb_en = 1'b0;
    checks++; errors++;
    $display("FAIL lsb_timeout addr=%h got lsb_done=0 required lsb_done=1", addr);
  endtask

  // Monitor: pops the scoreboard on every committed write and every done pulse.
  initial begin
    wexp_t w;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_wr === 1'b1 && bus.rdy === 1'b1) begin
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected got a=%h d=%h required no write cyc=%0d", bus.mem_a, bus.mem_dout, cyc);
          end else begin
            w = wq.pop_front();
            chk("mem_write", {bus.mem_a, bus.mem_dout}, {w.a, w.d});
          end
        end
        if (bus.if_done === 1'b1) begin
          if (dq.size() == 0 || !dq[0].is_if) begin
            checks++; errors++;
            $display("FAIL if_done_unexpected got if_done=1 required 0 cyc=%0d", cyc);
          end else begin
            e = dq.pop_front();
            chk("if_data", bus.if_data, e.data);
            if (e.cyc >= 0) chk("if_done_cycle", cyc, e.cyc);
          end
        end
        if (bus.lsb_done === 1'b1) begin
          if (dq.size() == 0 || dq[0].is_if) begin
            checks++; errors++;
            $display("FAIL lsb_done_unexpected got lsb_done=1 required 0 cyc=%0d", cyc);
          end else begin
            e = dq.pop_front();
            if (e.chk_data) chk("lsb_r_data", bus.lsb_r_data, e.data);
            if (e.cyc >= 0) chk("lsb_done_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1; ram_init = 1'b1;
    bus.rdy = 1'b1; bus.rollback = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_en = 1'b0; bus.if_pc = '0;
    bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_addr = '0; bus.lsb_len = '0; bus.lsb_w_data = '0;
    tick(2);
    ram_init = 1'b0;
    check_idle("reset");
    rst = 1'b0;
    tick(2);

    // Fetch of 4 bytes from 0x1000
    exp_done(1'b1, 1'b1, 32'h00100513, cyc + 6);
    if_drive(32'h1000);
    tick(1);

    // Store word, then loads of 4/2/1 bytes and a wrapping 2-byte load
    exp_wr(32'h2002, 8'hEF); exp_wr(32'h2003, 8'hBE); exp_wr(32'h2004, 8'hAD); exp_wr(32'h2005, 8'hDE);
    exp_done(1'b0, 1'b0, 32'h0, cyc + 5);
    lsb_drive(1'b1, 32'h2002, 3'd4, 32'hDEADBEEF);
    tick(1);
    exp_done(1'b0, 1'b1, 32'hDEADBEEF, cyc + 6);
    lsb_drive(1'b0, 32'h2002, 3'd4, 32'h0);
    tick(1);
    exp_done(1'b0, 1'b1, 32'h0000ADBE, cyc + 4);
    lsb_drive(1'b0, 32'h2003, 3'd2, 32'h0);
    tick(1);
    exp_done(1'b0, 1'b1, 32'h000000DE, cyc + 3);
    lsb_drive(1'b0, 32'h2005, 3'd1, 32'h0);
    tick(1);
    exp_done(1'b0, 1'b1, 32'h00006677, cyc + 4);
    lsb_drive(1'b0, 32'hFFFFFFFF, 3'd2, 32'h0);
    tick(1);

    // Contention held through reset: LSB first, then IF
    rst = 1'b1;
    fork
      if_drive(32'h1000);
      lsb_drive(1'b0, 32'h2002, 3'd4, 32'h0);
      begin
        tick(2);
        c = cyc;
        exp_done(1'b0, 1'b1, 32'hDEADBEEF, c + 6);
        exp_done(1'b1, 1'b1, 32'h00100513, c + 13);
        rst = 1'b0;
      end
    join
    tick(1);
    // last_grant=IF: simultaneous requests go LSB then IF
    c = cyc;
    exp_done(1'b0, 1'b1, 32'h0000ADBE, c + 4);
    exp_done(1'b1, 1'b1, 32'h00100513, c + 11);
    fork
      if_drive(32'h1000);
      lsb_drive(1'b0, 32'h2003, 3'd2, 32'h0);
    join
    tick(1);
    // After a lone LSB grant, simultaneous requests go IF then LSB
    exp_done(1'b0, 1'b1, 32'h000000DE, cyc + 3);
    lsb_drive(1'b0, 32'h2005, 3'd1, 32'h0);
    tick(1);
    c = cyc;
    exp_done(1'b1, 1'b1, 32'h00100513, c + 6);
    exp_done(1'b0, 1'b1, 32'hDEADBEEF, c + 13);
    fork
      if_drive(32'h1000);
      lsb_drive(1'b0, 32'h2002, 3'd4, 32'h0);
    join
    tick(1);

    // Rollback on the E2 edge of a fetch aborts it
    bus.if_pc = 32'h1000; bus.if_en = 1'b1;
    tick(2);
    bus.rollback = 1'b1;
    tick(1);
    bus.rollback = 1'b0; bus.if_en = 1'b0;
    chk("rb_mem_a", bus.mem_a, 0);
    chk("rb_mem_wr", bus.mem_wr, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("rb_no_if_done", bus.if_done, 0);
    end
    exp_done(1'b1, 1'b1, 32'h00100513, cyc + 6);
    if_drive(32'h1000);
    tick(1);

    // Rollback during a store is ignored
    exp_wr(32'h3100, 8'h44); exp_wr(32'h3101, 8'h33); exp_wr(32'h3102, 8'h22); exp_wr(32'h3103, 8'h11);
    exp_done(1'b0, 1'b0, 32'h0, cyc + 5);
    fork
      lsb_drive(1'b1, 32'h3100, 3'd4, 32'h11223344);
      begin
        tick(2);
        bus.rollback = 1'b1;
        tick(1);
        bus.rollback = 1'b0;
      end
    join
    tick(1);
    exp_done(1'b0, 1'b1, 32'h11223344, cyc + 6);
    lsb_drive(1'b0, 32'h3100, 3'd4, 32'h0);
    tick(1);

    // IO store stalled by a full buffer while a fetch proceeds
    c = cyc;
    bus.io_buffer_full = 1'b1;
    exp_done(1'b1, 1'b1, 32'h00100513, c + 6);
    exp_wr(32'h30000, 8'h5A);
    exp_done(1'b0, 1'b0, 32'h0, c + 12);
    fork
      if_drive(32'h1000);
      lsb_drive(1'b1, 32'h30000, 3'd1, 32'h0000005A);
      begin
        for (int i = 0; i < 10; i++) begin
          tick(1);
          chk("io_stall_mem_wr", bus.mem_wr, 0);
        end
        bus.io_buffer_full = 1'b0;
      end
    join
    tick(1);

    // rdy low for three edges stretches the fetch by three
    exp_done(1'b1, 1'b1, 32'h00100513, cyc + 9);
    fork
      if_drive(32'h1000);
      begin
        tick(2);
        bus.rdy = 1'b0;
        tick(3);
        bus.rdy = 1'b1;
      end
    join
    tick(1);

    // Reset after the first byte of a load drops it
    bus.lsb_wr = 1'b0; bus.lsb_addr = 32'h2002; bus.lsb_len = 3'd4; bus.lsb_en = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    bus.lsb_en = 1'b0;
    check_idle("mid_reset");
    rst = 1'b0;
    tick(4);
    exp_done(1'b0, 1'b1, 32'hDEADBEEF, cyc + 6);
    lsb_drive(1'b0, 32'h2002, 3'd4, 32'h0);
    tick(2);

    for (int i = 0; i < 100 && (dq.size() != 0 || wq.size() != 0); i++) tick(1);
    chk("pending_done", dq.size(), 0);
    chk("pending_writes", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
